// File: rtl/store_rmw_controller_if.sv
// Store controller bus: request/handshake from the control unit plus the
// data-memory port.
//   start, instr, addr, store_data : store request (control unit -> controller)
//   busy, done, fault              : status (controller -> control unit)
//   mem_addr, mem_rd, mem_wr,
//   mem_wdata                      : memory command (controller -> memory)
//   mem_rdata                      : memory read data (memory -> controller)
// The controller uses the slave modport; the requester/memory side uses master.
interface store_rmw_controller_if #(
    parameter int unsigned ADDR_W = 64
);
    logic              start;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] addr;
    logic [63:0]       store_data;
    logic              busy;
    logic              done;
    logic              fault;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [63:0]       mem_wdata;
    logic [63:0]       mem_rdata;

    modport master (
        output start, instr, addr, store_data, mem_rdata,
        input  busy, done, fault, mem_addr, mem_rd, mem_wr, mem_wdata
    );

    modport slave (
        input  start, instr, addr, store_data, mem_rdata,
        output busy, done, fault, mem_addr, mem_rd, mem_wr, mem_wdata
    );
endinterface

// File: rtl/store_rmw_controller.sv
// Store sequencer for a 64-bit data memory without byte enables.
// sd is a single aligned write; sb/sh/sw read the doubleword, merge the
// store lanes little-endian and write it back. Misaligned or illegal
// stores complete immediately with fault.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : store_rmw_controller_if.slave (request, status, memory port)
module store_rmw_controller #(
    parameter int unsigned READ_LAT = 1,   // 1..15
    parameter int unsigned ADDR_W   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    store_rmw_controller_if.slave  bus
);

    localparam int unsigned CNT_W     = 4;
    localparam logic [6:0]  OPC_STORE = 7'd35;

    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

    state_t            state;
    logic [1:0]        sz_q;      // log2 of store size in bytes
    logic [2:0]        off_q;     // byte offset within the doubleword
    logic [63:0]       data_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              busy_q;
    logic              done_q;
    logic              fault_q;
    logic              mem_rd_q;
    logic              mem_wr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [63:0]       mem_wdata_q;

    logic [2:0]        in_f3_c;
    logic              in_fault_c;
    logic [ADDR_W-1:0] aligned_c;
    logic [2:0]        lane_c;
    logic [7:0]        bmask_c;
    logic [63:0]       bitmask_c;
    logic [63:0]       shifted_c;
    logic [63:0]       merged_c;
    logic              unused_instr_c;

    // Instruction bits outside opcode/funct3 carry no meaning here.
    assign unused_instr_c = ^{bus.instr[31:15], bus.instr[11:7]};

    assign aligned_c = {bus.addr[ADDR_W-1:3], 3'b000};

    // Reject illegal funct3 and any store not naturally aligned to its size.
    always_comb begin
        in_f3_c    = bus.instr[14:12];
        in_fault_c = 1'b0;
        case (in_f3_c)
            3'd0:    in_fault_c = 1'b0;
            3'd1:    in_fault_c = bus.addr[0];
            3'd2:    in_fault_c = |bus.addr[1:0];
            3'd3:    in_fault_c = |bus.addr[2:0];
            default: in_fault_c = 1'b1;
        endcase
    end

    // Little-endian lane merge of the captured store data into the read data.
    always_comb begin
        lane_c    = off_q;
        bmask_c   = 8'h01;
        bitmask_c = '0;
        case (sz_q)
            2'd0: begin lane_c = off_q;                bmask_c = 8'h01; end
            2'd1: begin lane_c = {off_q[2:1], 1'b0};   bmask_c = 8'h03; end
            2'd2: begin lane_c = {off_q[2], 2'b00};    bmask_c = 8'h0F; end
            default: begin lane_c = 3'd0;              bmask_c = 8'hFF; end
        endcase
        bmask_c = bmask_c << lane_c;
        for (int i = 0; i < 8; i++) begin
            bitmask_c[i*8 +: 8] = {8{bmask_c[i]}};
        end
        shifted_c = data_q << {lane_c, 3'b000};
        merged_c  = (bus.mem_rdata & ~bitmask_c) | (shifted_c & bitmask_c);
    end

    // Sequencer; every output is a register updated alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            sz_q        <= '0;
            off_q       <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && (bus.instr[6:0] == OPC_STORE)) begin
                        sz_q   <= in_f3_c[1:0];
                        off_q  <= bus.addr[2:0];
                        data_q <= bus.store_data;
                        busy_q <= 1'b1;
                        if (in_fault_c) begin
                            state   <= DONE;
                            done_q  <= 1'b1;
                            fault_q <= 1'b1;
                        end else if (in_f3_c == 3'd3) begin
                            state       <= WRITE;
                            mem_wr_q    <= 1'b1;
                            mem_addr_q  <= aligned_c;
                            mem_wdata_q <= bus.store_data;
                        end else begin
                            state      <= READ;
                            mem_rd_q   <= 1'b1;
                            mem_addr_q <= aligned_c;
                        end
                    end
                end
                READ: begin
                    mem_rd_q <= 1'b0;
                    cnt_q    <= CNT_W'(READ_LAT - 1);
                    state    <= WAIT;
                end
                WAIT: begin
                    // Read data is valid on the last WAIT cycle; merge it straight in.
                    if (cnt_q == '0) begin
                        mem_wdata_q <= merged_c;
                        mem_wr_q    <= 1'b1;
                        state       <= WRITE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                WRITE: begin
                    mem_wr_q    <= 1'b0;
                    mem_wdata_q <= '0;
                    mem_addr_q  <= '0;
                    done_q      <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    fault_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.fault     = fault_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule
